// File: rtl/bin2bcd_scanner.sv
// ============================================================================
// Module   : bin2bcd_scanner
// Iterative double-dabble binary-to-BCD converter feeding a multiplexed
// active-low digit scanner for LED_7seg. Define LEADING_ZERO_BLANK_EN to
// blank digit slots above the most significant nonzero digit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_scanner #(
  parameter int BIN_W       = 14,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_digits,
  output logic [3:0]            BCD,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int          SCR_W   = 4 * DIGITS;
  localparam int          BCNT_W  = $clog2(BIN_W + 1);
  localparam int          RCNT_W  = $clog2(REFRESH_DIV);
  localparam int          IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q;
  logic [BIN_W-1:0]      bin_q;
  logic [SCR_W-1:0]      scr_q;
  logic [BCNT_W-1:0]     bcnt_q;
  logic                  ovf_next_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;
  logic [SCR_W-1:0]      bcd_q;

  logic [SCR_W-1:0]       scr_adj;
  logic [SCR_W+BIN_W-1:0] cat_d;
  logic [SCR_W-1:0]       scr_d;
  logic [BIN_W-1:0]       bin_d;
  logic                   ovf_in;

  // Add-3 correction on every nibble that would exceed 9 after doubling.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign cat_d  = {scr_adj, bin_q} << 1;
  assign scr_d  = cat_d[SCR_W+BIN_W-1:BIN_W];
  assign bin_d  = cat_d[BIN_W-1:0];
  assign ovf_in = (64'(bin_in) > MAX_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      bcnt_q     <= '0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bin_q      <= bin_in;
            scr_q      <= '0;
            bcnt_q     <= BCNT_W'(BIN_W);
            ovf_next_q <= ovf_in;
            busy_q     <= 1'b1;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scr_q  <= scr_d;
          bin_q  <= bin_d;
          bcnt_q <= bcnt_q - 1'b1;
          // busy drops with the last shift so it spans exactly BIN_W cycles.
          if (bcnt_q == BCNT_W'(1)) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_q   <= ovf_next_q ? {DIGITS{4'h9}} : scr_q;
          ovf_q   <= ovf_next_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [RCNT_W-1:0] rcnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        bcd_out_q;
  logic [DIGITS-1:0] sel_q;

  logic              wrap;
  logic [IDX_W-1:0]  idx_d;
  logic              blank;
  logic [DIGITS-1:0] sel_d;
  logic [3:0]        bcd_out_d;

  assign wrap  = (rcnt_q == RCNT_W'(REFRESH_DIV - 1));
  assign idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        msd = IDX_W'(i);
      end
    end
  end

  assign blank = (idx_d > msd);
`else
  assign blank = 1'b0;
`endif

  assign sel_d     = blank ? '1 : ~(DIGITS'(1) << idx_d);
  assign bcd_out_d = blank ? 4'd0 : bcd_q[{idx_d, 2'b00} +: 4];

  // Index, anode enable and digit value all move on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_q    <= '0;
      idx_q     <= '0;
      bcd_out_q <= 4'd0;
      sel_q     <= ~DIGITS'(1);
    end else if (wrap) begin
      rcnt_q    <= '0;
      idx_q     <= idx_d;
      bcd_out_q <= bcd_out_d;
      sel_q     <= sel_d;
    end else begin
      rcnt_q <= rcnt_q + 1'b1;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign bcd_digits = bcd_q;
  assign BCD        = bcd_out_q;
  assign digit_sel  = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_scanner.sv
// ============================================================================
// Module   : tb_bin2bcd_scanner
// Scoreboard bench for bin2bcd_scanner with directed conversion vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bin2bcd_scanner;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int RDIV   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy, done, overflow;
  logic [15:0] bcd_digits;
  logic [3:0]  BCD;
  logic [3:0]  digit_sel;

  bin2bcd_scanner #(
    .BIN_W       (BIN_W),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .bcd_digits (bcd_digits),
    .BCD        (BCD),
    .digit_sel  (digit_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  busy_run = 0;
  sb_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected result per done pulse, checks busy run length.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        chk("busy_len", busy_run, BIN_W);
        busy_run = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done with bcd=%h expected no done", bcd_digits);
        end else begin
          mon_e = sb.pop_front();
          chk("bcd_digits", bcd_digits, mon_e.bcd);
          chk("overflow", overflow, mon_e.ovf);
          chk("done_cycle", cyc, mon_e.cyc);
          chk("busy_at_done", busy, 1'b0);
        end
      end
    end
  end

  task automatic convert(input logic [13:0] v, input logic [15:0] eb, input logic eo,
                         input int extra_at, input logic [13:0] ev);
    sb_t it;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    it.bcd = eb;
    it.ovf = eo;
    it.cyc = cyc + BIN_W + 1;
    sb.push_back(it);
    for (int i = 1; i <= 40; i++) begin
      if (i == extra_at) begin
        start  = 1'b1;
        bin_in = ev;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected bcd=%h", eb);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic scan_check(input logic [15:0] v, input int ndark);
    int         dark;
    int         s;
    logic [3:0] oh;
    dark = 0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4 * RDIV; k++) begin
      if (digit_sel == 4'hF) begin
        dark++;
        chk("scan_dark_bcd", BCD, 4'd0);
      end else begin
        s = -1;
        for (int j = 0; j < DIGITS; j++) begin
          oh = ~(4'b0001 << j);
          if (digit_sel == oh) s = j;
        end
        if (s < 0) begin
          total++;
          bad++;
          $display("FAIL scan_onehot: got digit_sel=%b expected one-hot-low", digit_sel);
        end else begin
          chk("scan_bcd", BCD, v[4*s +: 4]);
        end
      end
      @(negedge clk);
    end
    chk("scan_dark_count", dark, ndark);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] esel;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_bcd", bcd_digits, 16'h0000);
    chk("rst_BCD", BCD, 4'd0);
    chk("rst_sel", digit_sel, 4'b1110);
    rst = 1'b0;

    // Idle scan: slot advances every RDIV clocks.
    for (int j = 0; j <= 4 * RDIV; j++) begin
      if ((j % RDIV == 0) || (j % RDIV == RDIV - 1)) begin
        esel = ~(4'b0001 << ((j / RDIV) % DIGITS));
`ifdef LEADING_ZERO_BLANK_EN
        if (((j / RDIV) % DIGITS) != 0) esel = 4'hF;
`endif
        chk("idle_sel", digit_sel, esel);
        chk("idle_BCD", BCD, 4'd0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
      end
      @(negedge clk);
    end

    convert(14'd1234, 16'h1234, 1'b0, 0, 14'd0);
    scan_check(16'h1234, 0);

    convert(14'd9999, 16'h9999, 1'b0, 0, 14'd0);
    convert(14'd0, 16'h0000, 1'b0, 0, 14'd0);

    convert(14'd12000, 16'h9999, 1'b1, 0, 14'd0);
    convert(14'd5, 16'h0005, 1'b0, 0, 14'd0);

    convert(14'd42, 16'h0042, 1'b0, 5, 14'd77);
`ifdef LEADING_ZERO_BLANK_EN
    scan_check(16'h0042, 2 * RDIV);
`else
    scan_check(16'h0042, 0);
`endif

    // Abort a conversion with reset mid-shift.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd500;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_bcd", bcd_digits, 16'h0000);
    chk("abort_ovf", overflow, 1'b0);
    chk("abort_BCD", BCD, 4'd0);
    chk("abort_sel", digit_sel, 4'b1110);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    convert(14'd500, 16'h0500, 1'b0, 0, 14'd0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin2bcd_scanner.md
Name: bin2bcd_scanner

Overview:
Upstream feeder for LED_7seg. It converts a binary count to packed BCD using an iterative double-dabble engine with a start/busy/done handshake. It then time-multiplexes the resulting digits onto a single 4-bit BCD bus, with active-low digit enables. LED_7seg consumes BCD directly; digit_sel drives the display anodes.

Parameters:
BIN_W, 14, width of binary input (max 16383).
DIGITS, 4, number of BCD digits produced and scanned (1..8).
REFRESH_DIV, 100000, clk cycles per displayed digit (1 kHz per digit at 100 MHz); must be >= 2.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to convert bin_in; sampled only in IDLE.
bin_in  input  BIN_W  binary value; sampled on the accepted start cycle only.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd_digits has been updated.
overflow  output  1  high if the last accepted bin_in exceeded 10^DIGITS-1; held until next accept.
bcd_digits  output  4*DIGITS  packed result, digit 0 (units) in bits [3:0].
BCD  output  4  currently scanned digit, to LED_7seg.BCD.
digit_sel  output  DIGITS  active-low one-hot anode enable.

Behaviour:
- Reset (async assert, sync to clk on release):
  - FSM enters IDLE.
  - busy=0, done=0, overflow=0, bcd_digits=0.
  - Refresh counter=0, scan index=0, BCD=0, digit_sel=~1 (digit 0 enabled).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 loads the bin shift register with bin_in, clears the BCD scratch register, and sets bit counter=BIN_W. overflow_next=(bin_in > 10^DIGITS-1). busy goes 1 on the next cycle. Go to SHIFT.
  - SHIFT: every cycle, add 3 to each scratch nibble >= 5, then shift {scratch,bin} left by 1 and decrement the counter. After the BIN_W-th shift, go to DONE.
  - DONE: write bcd_digits (all nibbles 4'h9 if overflow_next, else scratch) and overflow, pulse done=1, drop busy, return to IDLE.
- Latency: start accepted at edge N gives done=1 and new bcd_digits visible after edge N+BIN_W+1. busy is high for exactly BIN_W cycles.
- start while busy or in DONE: ignored, no queuing. The next conversion needs start in IDLE, which is earliest the cycle after done.
- bcd_digits and overflow change only in DONE, so the display never shows a partial result.
- Scratch width is 4*DIGITS. Bits shifted out of the top are discarded; overflow saturation covers this case.
- Scanner runs continuously and independently of the FSM:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances, wrapping DIGITS-1 -> 0.
  - digit_sel and BCD are registered and update on the same edge as the index, so they are always coherent.
  - BCD = bcd_digits[4*idx +: 4].
- bcd_digits updating mid-scan: BCD reflects the new value from the next index advance. No glitch within a digit slot.
- Reset asserted mid-conversion: conversion is aborted, outputs return to reset values, and no done pulse is produced.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: for a scanned digit above the most significant nonzero digit, digit_sel is all-ones (dark) for that slot and BCD=0. Digit 0 is always enabled, so value 0 shows "0". Blanking is computed from the registered bcd_digits.
- Undefined: every digit slot is enabled in turn; leading zeros are displayed.

Test Plan:
- Reset then idle, REFRESH_DIV=4 -> BCD=0; digit_sel cycles 1110,1101,1011,0111,1110 every 4 clks; busy=0, done=0.
- start with bin_in=14'd1234 -> busy high 14 cycles; done pulses 15 cycles after the start edge; bcd_digits=16'h1234; overflow=0.
- bin_in=14'd9999 then, after done, bin_in=14'd0 -> 16'h9999 then 16'h0000; each gets exactly one done pulse.
- bin_in=14'd12000 -> bcd_digits=16'h9999, overflow=1. A following conversion of 14'd5 clears overflow and gives 16'h0005.
- start pulsed again 5 cycles into a conversion of 14'd42 with bin_in=14'd77 -> second start ignored; result 16'h0042; one done pulse.
- reset asserted mid-SHIFT during a conversion of 14'd500 -> outputs return to reset values immediately; no done; a following start of 14'd500 gives 16'h0500.
- With LEADING_ZERO_BLANK_EN and value 14'd42 -> digit_sel slots 2,3 read 1111; slot 0 shows BCD=2 and slot 1 shows BCD=4.
